// File: rtl/score_renderer_if.sv
// Pixel/glyph bus for the score renderer.
// Carries the incoming pixel coordinates, the glyph lookup sent to the digit
// sprite ROMs and its returned rgb, and the final score-layer pixel.
// The master side (pixel source / ROM / compositor) drives pixel_row,
// pixel_col, pixel_valid and glyph_rgb. The slave side (score_renderer)
// drives glyph_row, glyph_col, glyph_digit, rgb and rgb_valid.
interface score_renderer_if;
  logic [9:0] pixel_row;
  logic [9:0] pixel_col;
  logic       pixel_valid;
  logic [9:0] glyph_row;
  logic [9:0] glyph_col;
  logic [3:0] glyph_digit;
  logic [2:0] glyph_rgb;
  logic [2:0] rgb;
  logic       rgb_valid;

  modport master (
    output pixel_row, pixel_col, pixel_valid, glyph_rgb,
    input  glyph_row, glyph_col, glyph_digit, rgb, rgb_valid
  );

  modport slave (
    input  pixel_row, pixel_col, pixel_valid, glyph_rgb,
    output glyph_row, glyph_col, glyph_digit, rgb, rgb_valid
  );
endinterface

// File: rtl/score_renderer.sv
// Score renderer: owns both players' scores and turns pixel coordinates into
// score-digit pixels for the frame compositor.
// Ports:
//   clk          pixel clock
//   reset_n      asynchronous active-low reset
//   pix          pixel/glyph bus (slave): pixel coords in, glyph lookup out,
//                glyph rgb in, score-layer rgb/rgb_valid out
//   frame_start  one-cycle pulse, latches the displayed scores
//   point_p1/2   one-cycle point pulses
//   clear_scores one-cycle new-game pulse
//   score_p1/2   live scores
//   game_over    a player reached WIN_SCORE
//   winner       0 = player 1, 1 = player 2 (valid when game_over)
// Pixel to rgb latency is two cycles, one pixel per clock.
module score_renderer #(
  parameter int unsigned P1_X      = 280,
  parameter int unsigned P2_X      = 349,
  parameter int unsigned DIGIT_Y   = 16,
  parameter int unsigned DIGIT_W   = 11,
  parameter int unsigned DIGIT_H   = 16,
  parameter int unsigned WIN_SCORE = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  score_renderer_if.slave   pix,
  input  logic              frame_start,
  input  logic              point_p1,
  input  logic              point_p2,
  input  logic              clear_scores,
  output logic [3:0]        score_p1,
  output logic [3:0]        score_p2,
  output logic              game_over,
  output logic              winner
);

  // Window bounds carry an extra bit so X+W never wraps in the compare.
  localparam logic [10:0] Y_LO  = 11'(DIGIT_Y);
  localparam logic [10:0] Y_HI  = 11'(DIGIT_Y + DIGIT_H);
  localparam logic [10:0] X1_LO = 11'(P1_X);
  localparam logic [10:0] X1_HI = 11'(P1_X + DIGIT_W);
  localparam logic [10:0] X2_LO = 11'(P2_X);
  localparam logic [10:0] X2_HI = 11'(P2_X + DIGIT_W);
  localparam logic [9:0]  Y_OFF  = 10'(DIGIT_Y);
  localparam logic [9:0]  X1_OFF = 10'(P1_X);
  localparam logic [9:0]  X2_OFF = 10'(P2_X);
  localparam logic [3:0]  WIN    = 4'(WIN_SCORE);

  function automatic logic in_range(input logic [9:0] v,
                                    input logic [10:0] lo,
                                    input logic [10:0] hi);
    return ({1'b0, v} >= lo) && ({1'b0, v} < hi);
  endfunction

  // Increment that saturates at the winning score.
  function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic en);
    if (en && (s < WIN)) return s + 4'd1;
    return s;
  endfunction

  logic [3:0] disp_p1, disp_p2;
  logic [3:0] p1_nxt, p2_nxt;
  logic       p1_reach, p2_reach;

  always_comb begin
    p1_nxt   = sat_inc(score_p1, point_p1);
    p2_nxt   = sat_inc(score_p2, point_p2);
    p1_reach = point_p1 && (p1_nxt == WIN);
    p2_reach = point_p2 && (p2_nxt == WIN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score_p1  <= '0;
      score_p2  <= '0;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else if (clear_scores) begin
      score_p1  <= '0;
      score_p2  <= '0;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else if (!game_over) begin
      score_p1 <= p1_nxt;
      score_p2 <= p2_nxt;
      if (p1_reach || p2_reach) begin
        game_over <= 1'b1;
        // Simultaneous reach goes to player 1.
        winner    <= p2_reach && !p1_reach;
      end
    end
  end

  // Displayed scores change only at frame start, using the pre-point value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_p1 <= '0;
      disp_p2 <= '0;
    end else if (frame_start) begin
      disp_p1 <= score_p1;
      disp_p2 <= score_p2;
    end
  end

  logic       in_w1, in_w2;
  logic       hit_c;
  logic [9:0] grow_c, gcol_c;
  logic [3:0] gdig_c;

  always_comb begin
    in_w1  = in_range(pix.pixel_row, Y_LO, Y_HI) &&
             in_range(pix.pixel_col, X1_LO, X1_HI);
    in_w2  = in_range(pix.pixel_row, Y_LO, Y_HI) &&
             in_range(pix.pixel_col, X2_LO, X2_HI);
    hit_c  = 1'b0;
    grow_c = '0;
    gcol_c = '0;
    gdig_c = '0;
    // Player 1 checked first so an overlapping window resolves to player 1.
    if (pix.pixel_valid && in_w1) begin
      hit_c  = 1'b1;
      grow_c = pix.pixel_row - Y_OFF;
      gcol_c = pix.pixel_col - X1_OFF;
      gdig_c = disp_p1;
    end else if (pix.pixel_valid && in_w2) begin
      hit_c  = 1'b1;
      grow_c = pix.pixel_row - Y_OFF;
      gcol_c = pix.pixel_col - X2_OFF;
      gdig_c = disp_p2;
    end
  end

  logic [9:0] glyph_row_p1, glyph_col_p1;
  logic [3:0] glyph_digit_p1;
  logic       hit_p1, vld_p1;
  logic [2:0] rgb_p2;
  logic       vld_p2;

  // Stage 1: window hit and glyph-local lookup to the ROMs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      glyph_row_p1   <= '0;
      glyph_col_p1   <= '0;
      glyph_digit_p1 <= '0;
      hit_p1         <= 1'b0;
      vld_p1         <= 1'b0;
    end else begin
      glyph_row_p1   <= grow_c;
      glyph_col_p1   <= gcol_c;
      glyph_digit_p1 <= gdig_c;
      hit_p1         <= hit_c;
      vld_p1         <= pix.pixel_valid;
    end
  end

  // Stage 2: ROM pixel gated by the hit flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_p2 <= '0;
      vld_p2 <= 1'b0;
    end else begin
      rgb_p2 <= hit_p1 ? pix.glyph_rgb : 3'b000;
      vld_p2 <= vld_p1;
    end
  end

  assign pix.glyph_row   = glyph_row_p1;
  assign pix.glyph_col   = glyph_col_p1;
  assign pix.glyph_digit = glyph_digit_p1;
  assign pix.rgb         = rgb_p2;
  assign pix.rgb_valid   = vld_p2;

endmodule
